// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the core instruction sequencer.
// Holds the inst bit map, the idle word, FSM states and latched tile config.
package core_ctrl_pkg;

    localparam int CORE_COL     = 8;
    localparam int CORE_ROW     = 4;
    localparam int CORE_MAX_LEN = 64;

    localparam int INST_W       = 34;
    localparam int LOAD_BIT     = 0;
    localparam int EXEC_BIT     = 1;
    localparam int L0_WR_BIT    = 2;
    localparam int L0_RD_BIT    = 3;
    localparam int OFIFO_RD_BIT = 6;
    localparam int XADDR_LSB    = 7;
    localparam int XADDR_W      = 11;
    localparam int XWEN_BIT     = 18;
    localparam int XCEN_BIT     = 19;
    localparam int PADDR_LSB    = 20;
    localparam int PADDR_W      = 11;
    localparam int PWEN_BIT     = 31;
    localparam int PCEN_BIT     = 32;
    localparam int ACCUM_BIT    = 33;

    // Both memories deselected (CEN=WEN=1), every control bit low.
    localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KLOAD,
        S_KPUSH,
        S_KGAP,
        S_XLOAD,
        S_EXEC,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic [9:0]  w_base;
        logic [9:0]  x_base;
        logic [10:0] p_base;
        logic [6:0]  x_len;
        logic        accum;
    } cfg_t;

    typedef struct packed {
        logic        load;
        logic        execute;
        logic        l0_wr;
        logic        l0_rd;
        logic        ofifo_rd;
        logic [9:0]  xmem_addr;
        logic        xmem_wen;
        logic        xmem_cen;
        logic [10:0] pmem_addr;
        logic        pmem_wen;
        logic        pmem_cen;
        logic        accum;
    } inst_fields_t;

endpackage

// File: rtl/core_ctrl_if.sv
// Host/core-facing bundle of the sequencer: tile config and start in,
// instruction word and status out.
interface core_ctrl_if;
    import core_ctrl_pkg::*;

    logic              start;
    logic [9:0]        w_base;
    logic [9:0]        x_base;
    logic [10:0]       p_base;
    logic [6:0]        x_len;
    logic              accum_en;
    logic              ofifo_valid;
    logic [INST_W-1:0] inst;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, w_base, x_base, p_base, x_len, accum_en, ofifo_valid,
        output inst, busy, done, err
    );

    modport slave (
        output start, w_base, x_base, p_base, x_len, accum_en, ofifo_valid,
        input  inst, busy, done, err
    );

endinterface

// File: rtl/core_ctrl_inst_pack.sv
// Packs decoded instruction fields into the 34-bit core inst word.
// xmem address is zero-extended, so the l0/ififo select bit stays 0.
module ctrl_inst_pack
    import core_ctrl_pkg::*;
(
    input  inst_fields_t      f,
    output logic [INST_W-1:0] inst_w
);

    always_comb begin
        inst_w                          = '0;
        inst_w[LOAD_BIT]                = f.load;
        inst_w[EXEC_BIT]                = f.execute;
        inst_w[L0_WR_BIT]               = f.l0_wr;
        inst_w[L0_RD_BIT]               = f.l0_rd;
        inst_w[OFIFO_RD_BIT]            = f.ofifo_rd;
        inst_w[XADDR_LSB +: XADDR_W]    = {1'b0, f.xmem_addr};
        inst_w[XWEN_BIT]                = f.xmem_wen;
        inst_w[XCEN_BIT]                = f.xmem_cen;
        inst_w[PADDR_LSB +: PADDR_W]    = f.pmem_addr;
        inst_w[PWEN_BIT]                = f.pmem_wen;
        inst_w[PCEN_BIT]                = f.pmem_cen;
        inst_w[ACCUM_BIT]               = f.accum;
    end

endmodule

// File: rtl/core_ctrl.sv
// One-tile sequencer for core: kernel load/push, activation load, execute,
// then drain the output FIFO into pmem (optionally accumulating).
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int COL     = CORE_COL,
    parameter int ROW     = CORE_ROW,
    parameter int MAX_LEN = CORE_MAX_LEN
)(
    input logic        clk,
    input logic        reset,
    core_ctrl_if.master bus
);

    localparam logic [6:0] KLOAD_LAST = 7'(COL);
    localparam logic [6:0] KPUSH_LAST = 7'(COL - 1);
    localparam logic [6:0] KGAP_LAST  = 7'(ROW + COL - 1);

    state_t            state, state_d;
    cfg_t              cfg, cfg_d;
    logic [6:0]        cnt, cnt_d;
    logic [6:0]        vec_n, vec_n_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              x_len_ok;
    logic [INST_W-1:0] inst_q, inst_d;
    inst_fields_t      f;

    assign x_len_ok = (bus.x_len != 7'd0) && (bus.x_len <= 7'(MAX_LEN));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cfg    <= '0;
            cnt    <= '0;
            vec_n  <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            inst_q <= IDLE_INST;
        end else begin
            state  <= state_d;
            cfg    <= cfg_d;
            cnt    <= cnt_d;
            vec_n  <= vec_n_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            done_q <= done_d;
            err_q  <= err_d;
            inst_q <= inst_d;
        end
    end

    // In DRAIN, cnt counts ofifo reads issued and vec_n counts pmem writes done.
    always_comb begin
        state_d = state;
        cfg_d   = cfg;
        cnt_d   = cnt + 7'd1;
        vec_n_d = vec_n;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    if (x_len_ok) begin
                        state_d      = S_KLOAD;
                        cfg_d.w_base = bus.w_base;
                        cfg_d.x_base = bus.x_base;
                        cfg_d.p_base = bus.p_base;
                        cfg_d.x_len  = bus.x_len;
                        cfg_d.accum  = bus.accum_en;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_KLOAD: if (cnt == KLOAD_LAST) begin
                state_d = S_KPUSH;
                cnt_d   = '0;
            end
            S_KPUSH: if (cnt == KPUSH_LAST) begin
                state_d = S_KGAP;
                cnt_d   = '0;
            end
            S_KGAP: if (cnt == KGAP_LAST) begin
                state_d = S_XLOAD;
                cnt_d   = '0;
            end
            S_XLOAD: if (cnt == cfg.x_len) begin
                state_d = S_EXEC;
                cnt_d   = '0;
            end
            S_EXEC: if (cnt == cfg.x_len - 7'd1) begin
                state_d = S_DRAIN;
                cnt_d   = '0;
                vec_n_d = '0;
                // Accum mode spends its first drain cycle letting the last result land.
                rd_d    = bus.ofifo_valid && !cfg.accum;
            end
            S_DRAIN: begin
                if (done_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    vec_n_d = '0;
                end else begin
                    cnt_d   = cnt + {6'd0, rd_q};
                    vec_n_d = vec_n + {6'd0, wr_q};
                    wr_d    = rd_q;
                    rd_d    = bus.ofifo_valid && (cnt_d < cfg.x_len)
                              && !(cfg.accum && rd_q);
                    done_d  = (vec_n_d == cfg.x_len);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Decode from next-cycle values so the registered inst lines up with the state.
    always_comb begin
        f          = '0;
        f.xmem_wen = 1'b1;
        f.xmem_cen = 1'b1;
        f.pmem_wen = 1'b1;
        f.pmem_cen = 1'b1;
        case (state_d)
            S_KLOAD: begin
                if (cnt_d < KLOAD_LAST) begin
                    f.xmem_cen  = 1'b0;
                    f.xmem_addr = cfg_d.w_base + 10'(cnt_d);
                end
                f.l0_wr = (cnt_d != 7'd0);
            end
            S_KPUSH: begin
                f.l0_rd = 1'b1;
                f.load  = 1'b1;
            end
            S_XLOAD: begin
                if (cnt_d < cfg_d.x_len) begin
                    f.xmem_cen  = 1'b0;
                    f.xmem_addr = cfg_d.x_base + 10'(cnt_d);
                end
                f.l0_wr = (cnt_d != 7'd0);
            end
            S_EXEC: begin
                f.l0_rd   = 1'b1;
                f.execute = 1'b1;
            end
            S_DRAIN: if (!done_d) begin
                f.ofifo_rd = rd_d;
                if (wr_d) begin
                    f.pmem_cen  = 1'b0;
                    f.pmem_wen  = 1'b0;
                    f.pmem_addr = cfg_d.p_base + 11'(vec_n_d);
                    f.accum     = cfg_d.accum;
                end else if (rd_d && cfg_d.accum) begin
                    f.pmem_cen  = 1'b0;
                    f.pmem_addr = cfg_d.p_base + 11'(vec_n_d);
                end
            end
            default: ;
        endcase
    end

    ctrl_inst_pack u_pack (
        .f      (f),
        .inst_w (inst_d)
    );

    assign bus.inst = inst_q;
    assign bus.busy = (state != S_IDLE);
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule
